frame_capture: RTL and testbench

Writer side of the 640x480 frame buffer: captures an OV7670-style camera stream (VSYNC/HREF framing, two bytes per RGB444 pixel) and turns it into 12-bit pixel writes with linear addresses. The display scan-out reads the same buffer at `addr = x + y*640`, so this block uses that same mapping. It sits between the camera pins and the frame-buffer BRAM write port.

---
 rtl/frame_capture.sv | 182 ++++++++++++++++++
 tb/tb_frame_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture.sv
// Camera-to-frame-buffer writer: assembles RGB444 byte pairs into 12-bit pixel writes at x + y*H_ACTIVE.
// Latency: second byte of a pixel sampled at edge n -> write strobe, address and data valid after edge n+1.
// Backpressure: none; one write every other cycle at most, the BRAM write port must take every strobe.
module frame_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480
) (
  input  logic        video_clk,
  input  logic        reset,
  input  logic        capture_en,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic [18:0] memory_addr,
  output logic [11:0] write_data,
  output logic        write_en,
  output logic        frame_done,
  output logic        busy
);

  // Window limits sized to the counters that are compared against them.
  localparam logic [10:0] X_LIMIT   = 11'(H_ACTIVE);
  localparam logic [9:0]  Y_LIMIT   = 10'(V_ACTIVE);
  localparam logic [18:0] LINE_STEP = 19'(H_ACTIVE);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_START = 2'd1,
    CAPTURE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Registered camera pins plus one extra delay on the framing strobes for edge detection.
  logic       vsync_q;
  logic       vsync_d;
  logic       href_q;
  logic       href_d;
  logic [7:0] data_q;

  logic vsync_fall;
  logic vsync_rise;
  logic href_fall;

  // FSM decodes
  logic frame_start;
  logic frame_end;

  // Pixel assembly state
  logic        byte_phase;
  logic [3:0]  red_nib;
  logic [10:0] x;
  logic [9:0]  y;
  logic [18:0] line_base;

  logic in_capture;
  logic pixel_done;
  logic in_window;
  logic pixel_write;

  assign vsync_fall = vsync_d & ~vsync_q;
  assign vsync_rise = ~vsync_d & vsync_q;
  assign href_fall  = href_d & ~href_q;

  assign in_capture  = (state == CAPTURE);
  // A pixel completes on the second byte of a pair; the line-end edge never coincides with a byte.
  assign pixel_done  = in_capture & href_q & byte_phase;
  assign in_window   = (x < X_LIMIT) && (y < Y_LIMIT);
  assign pixel_write = pixel_done & in_window;

  // Register the camera pins once so every decision below sees a single-cycle-aligned view.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      data_q  <= 8'd0;
    end else begin
      vsync_q <= cam_vsync;
      vsync_d <= vsync_q;
      href_q  <= cam_href;
      href_d  <= href_q;
      data_q  <= cam_data;
    end
  end

  // State register.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: arm on enable, start on vsync fall, always finish a started frame on vsync rise.
  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (capture_en) begin
          state_next = WAIT_START;
        end
      end
      WAIT_START: begin
        if (!capture_en) begin
          state_next = IDLE;
        end else if (vsync_fall) begin
          state_next  = CAPTURE;
          frame_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          frame_end  = 1'b1;
          state_next = capture_en ? WAIT_START : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Byte pairing and x/y/line_base tracking; line end and frame end may land on the same cycle.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      byte_phase <= 1'b0;
      red_nib    <= 4'd0;
      x          <= 11'd0;
      y          <= 10'd0;
      line_base  <= 19'd0;
    end else if (frame_start) begin
      byte_phase <= 1'b0;
      x          <= 11'd0;
      y          <= 10'd0;
      line_base  <= 19'd0;
    end else if (in_capture) begin
      if (href_fall) begin
        // An unpaired trailing byte is dropped by resetting the phase here.
        byte_phase <= 1'b0;
        x          <= 11'd0;
        if (y < Y_LIMIT) begin
          y         <= y + 10'd1;
          line_base <= line_base + LINE_STEP;
        end
      end else if (href_q) begin
        byte_phase <= ~byte_phase;
        if (!byte_phase) begin
          red_nib <= data_q[3:0];
        end else if (x < X_LIMIT) begin
          // x stops at the limit: anything past it is clipped anyway and the counter cannot wrap.
          x <= x + 11'd1;
        end
      end
    end
  end

  // Registered write port and status outputs; address and data hold between strobes.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      memory_addr <= 19'd0;
      write_data  <= 12'd0;
      write_en    <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      write_en   <= pixel_write;
      frame_done <= frame_end;
      busy       <= in_capture;
      if (pixel_write) begin
        memory_addr <= line_base + {8'd0, x};
        write_data  <= {red_nib, data_q};
      end
    end
  end

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture: drives camera frames, predicts writes from the byte stream, compares.
// Uses a reduced 20x12 window so full frames stay short; address step follows H_ACTIVE.
module tb_frame_capture;

  localparam int H = 20;
  localparam int V = 12;

  logic        video_clk = 1'b0;
  logic        reset = 1'b1;
  logic        capture_en = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'd0;
  logic [18:0] memory_addr;
  logic [11:0] write_data;
  logic        write_en;
  logic        frame_done;
  logic        busy;

  frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
    .video_clk   (video_clk),
    .reset       (reset),
    .capture_en  (capture_en),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .memory_addr (memory_addr),
    .write_data  (write_data),
    .write_en    (write_en),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  always #5 video_clk = ~video_clk;

  int cyc = 0;
  always @(posedge video_clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Observed writes and frame_done pulses
  int wa[$];
  int wd[$];
  int wc[$];
  int fd_cnt = 0;
  bit prev_we = 1'b0;
  bit prev_fd = 1'b0;

  always @(negedge video_clk) begin
    if (write_en) begin
      chk(!prev_we, "we_back_to_back", 1, 0);
      wa.push_back(int'(memory_addr));
      wd.push_back(int'(write_data));
      wc.push_back(cyc);
    end
    if (frame_done) begin
      fd_cnt <= fd_cnt + 1;
      chk(busy == 1'b1, "busy_at_done", longint'(busy), 1);
      chk(write_en == 1'b0, "write_with_done", longint'(write_en), 0);
    end
    if (prev_fd) chk(busy == 1'b0 && frame_done == 1'b0, "busy_after_done", longint'({busy, frame_done}), 0);
    prev_we <= write_en;
    prev_fd <= frame_done;
  end

  // Frame description and expectations
  logic [7:0] fb[$];
  int flen[$];
  int bc[$];
  int ea[$];
  int ed[$];
  int wbase, bcbase, fdbase;
  int rst_line = -1;
  int en_off_line = -1;
  int en_on_line = -1;
  bit cur_cap;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] exp;
  } vec_t;
  vec_t tv[6];

  task automatic step();
    @(posedge video_clk);
    #1;
  endtask

  task automatic make_frame(input int nl, input int lo, input int hi);
    fb.delete();
    flen.delete();
    for (int l = 0; l < nl; l++) begin
      int n;
      n = $urandom_range(hi, lo);
      flen.push_back(n);
      for (int b = 0; b < n; b++) fb.push_back(8'($urandom));
    end
  endtask

  // Reference: each line contributes floor(len/2) pixels; pixel p of line y is written at y*H+p
  // when inside the window, with data {first byte low nibble, second byte}. Stop at a reset line.
  task automatic model(input bit cap, input int stop_line);
    int o;
    ea.delete();
    ed.delete();
    o = 0;
    if (cap) begin
      for (int l = 0; l < flen.size(); l++) begin
        if (l == stop_line) break;
        for (int p = 0; p < flen[l] / 2; p++) begin
          if (p < H && l < V) begin
            ea.push_back(l * H + p);
            ed.push_back(int'({fb[o + 2 * p][3:0], fb[o + 2 * p + 1]}));
          end
        end
        o += flen[l];
      end
    end
  endtask

  task automatic send_frame(input int tail_gap);
    int off;
    off = 0;
    cam_href = 1'b0;
    cam_vsync = 1'b1;
    repeat (4) step();
    cam_vsync = 1'b0;
    repeat (2) step();
    for (int l = 0; l < flen.size(); l++) begin
      if (l == rst_line) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk(memory_addr == 19'd0, "rst_addr", longint'(memory_addr), 0);
        chk(write_data == 12'd0, "rst_data", longint'(write_data), 0);
        chk(write_en == 1'b0, "rst_we", longint'(write_en), 0);
        chk(frame_done == 1'b0, "rst_done", longint'(frame_done), 0);
        chk(busy == 1'b0, "rst_busy", longint'(busy), 0);
      end
      if (l == en_off_line) capture_en = 1'b0;
      if (l == en_on_line) capture_en = 1'b1;
      if (l == 1 && (rst_line < 0 || rst_line > 1))
        chk(busy == cur_cap, "busy_mid", longint'(busy), longint'(cur_cap));
      cam_href = 1'b1;
      for (int b = 0; b < flen[l]; b++) begin
        cam_data = fb[off + b];
        step();
        if (b % 2 == 1) bc.push_back(cyc);
      end
      off += flen[l];
      cam_href = 1'b0;
      cam_data = 8'($urandom);
      if (l == flen.size() - 1) begin
        if (tail_gap > 0) repeat (tail_gap) step();
        cam_vsync = 1'b1;
      end else begin
        repeat ($urandom_range(3, 1)) step();
      end
    end
    repeat (4) step();
  endtask

  task automatic compare(input string tag, input bit exp_done);
    int n, bad, m;
    n = wa.size() - wbase;
    chk(n == ea.size(), {tag, "_count"}, n, ea.size());
    m = (n < ea.size()) ? n : ea.size();
    bad = -1;
    for (int i = 0; i < m; i++) begin
      if (bad < 0 && (wa[wbase + i] != ea[i] || wd[wbase + i] != ed[i])) bad = i;
    end
    chk(bad < 0, {tag, "_first_bad_write"}, bad, -1);
    chk(fd_cnt - fdbase == int'(exp_done), {tag, "_frame_done"}, fd_cnt - fdbase, int'(exp_done));
    chk(busy == 1'b0, {tag, "_busy_end"}, longint'(busy), 0);
  endtask

  task automatic run_frame(input string tag, input int tail_gap);
    bit cap;
    cap = capture_en;
    cur_cap = cap;
    wbase = wa.size();
    bcbase = bc.size();
    fdbase = fd_cnt;
    model(cap, rst_line);
    send_frame(tail_gap);
    repeat (2) step();
    compare(tag, cap && rst_line < 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = '{8'hFA, 8'h5C, 12'hA5C};
    tv[1] = '{8'h03, 8'h21, 12'h321};
    tv[2] = '{8'hFF, 8'hFF, 12'hFFF};
    tv[3] = '{8'h00, 8'h00, 12'h000};
    tv[4] = '{8'hA0, 8'h0B, 12'h00B};
    tv[5] = '{8'h5F, 8'hC3, 12'hFC3};

    // Reset state
    repeat (3) step();
    chk(memory_addr == 19'd0, "reset_addr", longint'(memory_addr), 0);
    chk(write_data == 12'd0, "reset_data", longint'(write_data), 0);
    chk(write_en == 1'b0, "reset_we", longint'(write_en), 0);
    chk(frame_done == 1'b0, "reset_done", longint'(frame_done), 0);
    chk(busy == 1'b0, "reset_busy", longint'(busy), 0);
    reset = 1'b0;
    step();

    // Full frame
    capture_en = 1'b1;
    repeat (2) step();
    make_frame(V, 2 * H, 2 * H);
    run_frame("full", 2);
    chk(wa.size() > 0 && wa[wa.size() - 1] == H * V - 1, "full_last_addr",
        (wa.size() > 0) ? wa[wa.size() - 1] : -1, H * V - 1);

    // Byte assembly table, one line
    fb.delete();
    flen.delete();
    for (int i = 0; i < 6; i++) begin
      fb.push_back(tv[i].b0);
      fb.push_back(tv[i].b1);
    end
    flen.push_back(12);
    run_frame("table", 2);
    for (int i = 0; i < 6; i++) begin
      if (wa.size() > wbase + i) begin
        chk(wd[wbase + i] == int'(tv[i].exp), "tv_data", wd[wbase + i], tv[i].exp);
        chk(wa[wbase + i] == i, "tv_addr", wa[wbase + i], i);
        chk(wc[wbase + i] - bc[bcbase + i] == 1, "tv_latency", wc[wbase + i] - bc[bcbase + i], 1);
      end else begin
        chk(1'b0, "tv_missing_write", i, 6);
      end
    end

    // Short odd line then a normal line
    make_frame(2, 4, 4);
    flen[0] = 5;
    fb.push_back(8'h77);
    run_frame("odd_line", 2);
    chk(wa.size() > wbase + 2 && wa[wbase + 2] == H, "odd_line2_addr",
        (wa.size() > wbase + 2) ? wa[wbase + 2] : -1, H);

    // Overlong lines and extra lines
    make_frame(V + 2, 2 * H + 4, 2 * H + 4);
    run_frame("overlong", 2);
    chk(wa.size() - wbase == H * V, "overlong_total", wa.size() - wbase, H * V);

    // Line end and frame end on the same cycle
    make_frame(3, 2, 10);
    run_frame("simul_end", 0);

    // Enable low for a whole frame
    capture_en = 1'b0;
    repeat (2) step();
    make_frame(V, 2 * H, 2 * H);
    run_frame("en_low", 2);

    // Drop enable mid-frame: frame completes, next one is ignored
    capture_en = 1'b1;
    repeat (2) step();
    en_off_line = 5;
    make_frame(V, 2 * H, 2 * H);
    run_frame("en_drop", 2);
    en_off_line = -1;
    make_frame(V, 2 * H, 2 * H);
    run_frame("after_drop", 2);

    // Raise enable mid-frame: nothing until the next vsync fall
    en_on_line = 4;
    make_frame(V, 2 * H, 2 * H);
    run_frame("en_rise", 2);
    en_on_line = -1;
    make_frame(V, 2 * H, 2 * H);
    run_frame("armed", 2);

    // Reset mid-frame, then resume at address 0
    rst_line = 6;
    make_frame(V, 2 * H, 2 * H);
    run_frame("rst_mid", 2);
    rst_line = -1;
    make_frame(V, 2 * H, 2 * H);
    run_frame("after_rst", 2);

    // Random frames: odd/short/long lines, extra or missing lines, random tail gap
    for (int k = 0; k < 4; k++) begin
      make_frame($urandom_range(V + 3, V - 2), 1, 2 * H + 5);
      run_frame("random", $urandom_range(3, 0));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
